muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Parametrised sequential multiply/divide unit, the next generation of the fixed 32-bit mult and div blocks that feed the HI/LO registers. One shared iterative datapath executes signed and unsigned multiply and divide under a start/busy/done handshake. Divide-by-zero is flagged for the exception logic. The unit sits beside the ALU; operands come from the A/B registers and results go to HI/LO.

## Interface

Parameters:
- WIDTH, 32, operand width in bits. Must be at least 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation. Sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  multiplicand or dividend. Captured when start is accepted.
- b  in  WIDTH  multiplier or divisor. Captured when start is accepted.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: the operation has finished.
- div_zero  out  1  one-cycle pulse together with done: divisor was zero.
- hi  out  WIDTH  MULT: upper product half. DIV: remainder.
- lo  out  WIDTH  MULT: lower product half. DIV: quotient.

## Operation

- States: IDLE, RUN, FIX.
- **IDLE**
  - start=1 captures op, a and b.
  - Operands are converted to magnitudes when op is signed. Result signs are recorded.
  - Divide with b=0: go straight to IDLE, pulse done and div_zero next cycle, leave hi/lo unchanged.
  - Otherwise go to RUN with the step counter set to WIDTH.
- **RUN**
  - One step per cycle; counter decrements. Go to FIX when the counter reaches 0.
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract (partial remainder WIDTH+1 bits, quotient shifted in).
- **FIX**
  - Apply sign correction, register hi/lo, pulse done, return to IDLE.
  - MULT: 2·WIDTH product negated when operand signs differ.
  - DIV: quotient truncates toward zero. Remainder takes the dividend's sign.
- Arithmetic rules:
  - Most-negative / -1 yields lo = most negative (wraps) and hi = 0. No flag is raised.
  - MULTU/DIVU treat operands as unsigned.
- start while busy is ignored.
- start during the done cycle is accepted, because the unit is in IDLE.
- hi/lo hold their value until the next successful completion. A div_zero completion does not change them.

## Timing

- Reset values: state IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0.
- Reset takes effect immediately, including mid-operation. The operation in progress is aborted and no done is issued.
- Normal operation, with start accepted in cycle 0:
  - busy is high in cycles 1..WIDTH+1.
  - hi/lo update and done is high in cycle WIDTH+2 (34 for WIDTH=32); busy is low in that cycle.
- Divide by zero: done=div_zero=1 in cycle 1. busy is never asserted.
- done, div_zero, hi and lo are all registered outputs; no combinational path runs from inputs to outputs.
- Back-to-back throughput: one operation per WIDTH+2 cycles.

## Structure

- Shared package muldiv_pkg holds:
  - the op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state typedef (IDLE, RUN, FIX).
- One sub-module is natural: muldiv_step.
  - Purely combinational single-iteration step, parametrised by WIDTH.
  - Multiply mode: add-and-shift of the accumulator.
  - Divide mode: trial subtract and shift.
  - The top level holds the FSM, counter, operand/sign registers and the FIX stage.
- The CPU's separate HI/LO source muxes collapse into a single source once this unit replaces mult/div.

## Test plan

All scenarios use WIDTH=32.

- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done in cycle 34, exactly one cycle wide.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). div_zero=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- DIVU a=100, b=0 after a prior result hi=5/lo=9 -> done=div_zero=1 in cycle 1; hi=5, lo=9 unchanged; busy never high.
- MULTU 6·7 with start pulsed again in cycle 5 and reset asserted in cycle 10:
  - the second start is ignored;
  - on reset, busy/done/hi/lo become 0 immediately;
  - no done is seen;
  - a fresh MULTU 6·7 then gives lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings and FSM state type shared by the multiply/divide unit.
package muldiv_pkg;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   d_i,
  output logic [2*WIDTH-1:0] acc_o
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] sub;
  logic             ge;
  always_comb begin
    sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, d_i} : '0);
    rem = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    ge  = rem >= {1'b0, d_i};
    // rem - d < d whenever it is taken, so the low WIDTH bits are exact
    sub = rem[WIDTH-1:0] - d_i;
    acc_o = div_i ? {(ge ? sub : rem[WIDTH-1:0]), acc_i[WIDTH-2:0], ge}
                  : {sum, acc_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed/unsigned multiply and divide producing HI/LO results.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 div_q, neg_q, rneg_q, done_q, dz_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d, prod;
  logic [WIDTH-1:0]     d_q, hi_q, lo_q, a_mag, b_mag, q_fix, r_fix;
  logic                 a_neg, b_neg;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i(div_q),
    .acc_i(acc_q),
    .d_i  (d_q),
    .acc_o(acc_d)
  );
  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    prod  = neg_q ? -acc_q : acc_q;
    q_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    r_fix = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      acc_q   <= '0;
      d_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (op[1] && b == '0) begin
            done_q <= 1'b1;
            dz_q   <= 1'b1;
          end else begin
            state_q <= RUN;
            cnt_q   <= CW'(WIDTH);
            div_q   <= op[1];
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            acc_q   <= {{WIDTH{1'b0}}, a_mag};
            d_q     <= b_mag;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= div_q ? r_fix : prod[2*WIDTH-1:WIDTH];
          lo_q    <= div_q ? q_fix : prod[WIDTH-1:0];
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table plus reset/ignored-start sequence for muldiv_seq.
module tb_muldiv_seq;
  import muldiv_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, div_zero;
  logic [W-1:0] hi, lo;
  int total = 0, passed = 0;
  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dz;
  } vec_t;
  vec_t vecs[14];
  always #5 clk = ~clk;
  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic run(input vec_t v, input string tag);
    int cyc, nbusy;
    @(negedge clk);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    nbusy = 0;
    while (!done && cyc < 100) begin
      nbusy += int'(busy);
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), v.dz ? 64'd1 : 64'(W + 2));
    check({tag, "_busy_cycles"}, 64'(nbusy), v.dz ? 64'd0 : 64'(W + 1));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_div_zero"}, 64'(div_zero), 64'(v.dz));
    check({tag, "_hi"}, 64'(hi), 64'(v.hi));
    check({tag, "_lo"}, 64'(lo), 64'(v.lo));
    @(negedge clk);
    check({tag, "_done_width"}, 64'({done, div_zero}), 64'd0);
  endtask
  initial begin
    bit saw;
    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[5]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[6]  = '{OP_DIV,   32'hFFFFFFF8, 32'd3,        32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0};
    vecs[7]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[8]  = '{OP_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0};
    vecs[9]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[10] = '{OP_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 1'b0};
    vecs[11] = '{OP_DIVU,  32'd59,       32'd6,        32'd5,        32'd9,        1'b0};
    vecs[12] = '{OP_DIVU,  32'd100,      32'd0,        32'd5,        32'd9,        1'b1};
    vecs[13] = '{OP_DIV,   32'd5,        32'd0,        32'd5,        32'd9,        1'b1};
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_div_zero", 64'(div_zero), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 14; i++) run(vecs[i], $sformatf("vec%0d", i));
    // abort sequence: a busy-time start is ignored, then reset mid-operation
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd6; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start_busy", 64'(busy), 64'd1);
    check("ignored_start_done", 64'({done, div_zero}), 64'd0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw |= done;
    end
    check("no_done_after_abort", 64'(saw), 64'd0);
    run('{OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0}, "fresh");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
